// File: rtl/vfd_scanout_if.sv
// VRAM read-port bundle between the scanout block and the second VRAM port.
interface vfd_scanout_if;
  logic [18:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;

  modport master (
    output vram_addr,
    output vram_rd,
    input  vram_data
  );

  modport slave (
    input  vram_addr,
    input  vram_rd,
    output vram_data
  );
endinterface

// File: rtl/vfd_scanout.sv
// VFD frame-buffer scanout: walks the raster, reads RGB332 pixels from VRAM
// in raster order and emits 8-bit RGB with aligned syncs and blanks.
// Stage 0 owns the raster counters and the VRAM address; stage 1 registers
// the returned pixel together with the delayed timing flags.
module vfd_scanout #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce_pix,
  input  logic                 enable,
  vfd_scanout_if.master        vram,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblank,
  output logic                 vblank,
  output logic                 frame_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_ACT_C   = 10'(H_ACT);
  localparam logic [9:0]  H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0]  HS_BEG    = 10'(H_ACT + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_ACT_C   = 10'(V_ACT);
  localparam logic [9:0]  V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [18:0] ADDR_LAST = 19'(H_ACT * V_ACT - 1);

  // Bit-replicating expansion keeps full-scale codes at 8'hFF and zero at 0.
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [18:0] ptr;
  logic        active;

  logic [9:0]  hcnt_p0;
  logic [9:0]  vcnt_p0;
  logic        en_p0;
  logic        vld_p0;

  logic        hb_p0;
  logic        vb_p0;
  logic        hs_p0;
  logic        vs_p0;

  // ---------------- stage 0: raster counters and VRAM address ----------------

  assign active = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);

  // Raster position advances one pixel per ce_pix, wrapping line and frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce_pix) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Incremental read pointer; re-zeroed on the first vblank line so a frame
  // cut short still leaves the next one starting at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (ce_pix) begin
      if (vcnt == V_ACT_C)
        ptr <= '0;
      else if (active && (ptr != ADDR_LAST))
        ptr <= ptr + 19'd1;
    end
  end

  // Issue the VRAM read for active pixels; strobe lasts a single clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram.vram_addr <= '0;
      vram.vram_rd   <= 1'b0;
    end else begin
      vram.vram_rd <= 1'b0;
      if (ce_pix) begin
        vram.vram_rd <= active;
        if (active)
          vram.vram_addr <= ptr;
      end
    end
  end

  // Carry the raster position and enable alongside the outstanding read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
      en_p0   <= 1'b0;
      vld_p0  <= 1'b0;
    end else if (ce_pix) begin
      hcnt_p0 <= hcnt;
      vcnt_p0 <= vcnt;
      en_p0   <= enable;
      vld_p0  <= 1'b1;
    end
  end

  // ---------------- stage 1: pixel and timing outputs ----------------

  assign hb_p0 = (hcnt_p0 >= H_ACT_C);
  assign vb_p0 = (vcnt_p0 >= V_ACT_C);
  assign hs_p0 = (hcnt_p0 >= HS_BEG) && (hcnt_p0 <= HS_END);
  assign vs_p0 = (vcnt_p0 >= VS_BEG) && (vcnt_p0 <= VS_END);

  // Register colour and timing together so every output shares one lag;
  // outputs stay put until stage 0 has produced its first pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (ce_pix && vld_p0) begin
        hblank      <= hb_p0;
        vblank      <= vb_p0;
        hsync       <= hs_p0;
        vsync       <= vs_p0;
        frame_start <= (hcnt_p0 == 10'd0) && (vcnt_p0 == 10'd0);
        if (en_p0 && !hb_p0 && !vb_p0) begin
          red   <= expand3(vram.vram_data[7:5]);
          green <= expand3(vram.vram_data[4:2]);
          blue  <= expand2(vram.vram_data[1:0]);
        end else begin
          red   <= '0;
          green <= '0;
          blue  <= '0;
        end
      end
    end
  end

endmodule
